// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin owner of one shared add/subtract datapath for two requesters
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   req0_i/req1_i                    requests, held until matching ack
//   op0_i/op1_i                      0 = a+b, 1 = a-b
//   a0_i, b0_i, a1_i, b1_i           two's-complement operands, latched at grant
//   ack0_o/ack1_o                    one-cycle result-valid pulse for the owner
//   s_o, co_o, ovf_o                 registered result, raw carry-out, signed overflow
//   owner_o                          most recently granted requester
//   busy_o                           high while a transaction is in flight
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic             op0_i,
    input  logic             op1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ovf_o,
    output logic             owner_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           state_q;
    logic             last_q, owner_q, rop_q, co_q, ovf_q, ack0_q, ack1_q, busy_q;
    logic [WIDTH-1:0] ra_q, rb_q, s_q;
    logic             gnt_d, ovf_d;
    logic [WIDTH:0]   sum_d;
    // Only requester 1 pending, or both pending and requester 1 not served last.
    assign gnt_d = req1_i & (~req0_i | ~last_q);
    // Subtraction is a + ~b + 1, so carry-out set means no borrow.
    assign sum_d = {1'b0, ra_q} + {1'b0, rb_q ^ {WIDTH{rop_q}}} + {{WIDTH{1'b0}}, rop_q};
    assign ovf_d = (ra_q[WIDTH-1] == (rb_q[WIDTH-1] ^ rop_q)) & (sum_d[WIDTH-1] != ra_q[WIDTH-1]);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            rop_q   <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req0_i | req1_i) begin
                    owner_q <= gnt_d;
                    ra_q    <= gnt_d ? a1_i : a0_i;
                    rb_q    <= gnt_d ? b1_i : b0_i;
                    rop_q   <= gnt_d ? op1_i : op0_i;
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    s_q     <= sum_d[WIDTH-1:0];
                    co_q    <= sum_d[WIDTH];
                    ovf_q   <= ovf_d;
                    ack0_q  <= ~owner_q;
                    ack1_q  <= owner_q;
                    state_q <= DONE;
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack0_o  = ack0_q;
    assign ack1_o  = ack1_q;
    assign s_o     = s_q;
    assign co_o    = co_q;
    assign ovf_o   = ovf_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized check of addsub_arbiter against an arithmetic reference
module tb_addsub_arbiter;
    localparam int W = 8;
    logic         clk = 1'b0, rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         ack0, ack1, co, ovf, owner, busy;
    logic [W-1:0] s;
    int           n_vec = 0, n_err = 0;
    int           ph = 0;
    bit           m_last = 1'b1, m_owner = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0, m_busy = 1'b0;
    bit           m_co = 1'b0, m_ovf = 1'b0, p_co = 1'b0, p_ovf = 1'b0;
    logic [W-1:0] m_s = '0, p_s = '0;
    int           order[$];
    addsub_arbiter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1), .op0_i(op0), .op1_i(op1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .ack0_o(ack0), .ack1_o(ack1), .s_o(s), .co_o(co), .ovf_o(ovf),
        .owner_o(owner), .busy_o(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Result from plain integer arithmetic: signed range test for overflow, unsigned compare for carry.
    task automatic calc(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output bit c, output bit v);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sr = op ? sa - sb : sa + sb;
        v  = (sr > 127) || (sr < -128);
        c  = op ? (ua >= ub) : (ua + ub > 255);
        r  = W'(op ? ua - ub : ua + ub);
    endtask
    // ph counts cycles since grant: 0 idle, 1 computing, 2 acknowledging.
    task automatic model_edge();
        bit w;
        if (rst) begin
            ph = 0; m_last = 1; m_owner = 0; m_ack0 = 0; m_ack1 = 0; m_busy = 0;
            m_s = '0; m_co = 0; m_ovf = 0;
        end else if (ph == 0) begin
            if (req0 || req1) begin
                w = (req0 && req1) ? !m_last : req1;
                m_owner = w;
                calc(w ? op1 : op0, w ? a1 : a0, w ? b1 : b0, p_s, p_co, p_ovf);
                m_busy = 1;
                ph = 1;
            end
        end else if (ph == 1) begin
            m_s = p_s; m_co = p_co; m_ovf = p_ovf;
            m_ack0 = !m_owner; m_ack1 = m_owner;
            ph = 2;
        end else begin
            m_ack0 = 0; m_ack1 = 0; m_last = m_owner; m_busy = 0;
            ph = 0;
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("ack0", ack0, m_ack0);
        check("ack1", ack1, m_ack1);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        check("s", s, m_s);
        check("co", co, m_co);
        check("ovf", ovf, m_ovf);
    endtask
    task automatic txn(input bit n, input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input bit ec, input bit ev);
        if (n) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        cyc();
        check("grant_owner", owner, n);
        cyc();
        check("dir_ack", n ? ack1 : ack0, 1);
        check("dir_other_ack", n ? ack0 : ack1, 0);
        check("dir_s", s, es);
        check("dir_co", co, ec);
        check("dir_ovf", ovf, ev);
        req0 = 0; req1 = 0;
        cyc();
        check("dir_ack_drop", ack0 | ack1, 0);
    endtask
    initial begin
        cyc();
        cyc();
        check("rst_s", s, 0);
        check("rst_busy", busy, 0);
        rst = 0;
        cyc();
        txn(0, 0, 8'h7F, 8'h01, 8'h80, 0, 1);
        txn(1, 1, 8'h80, 8'h01, 8'h7F, 1, 1);
        txn(1, 1, 8'h05, 8'h05, 8'h00, 1, 0);
        txn(0, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
        // Operands changed right after the grant edge must not affect the result.
        req0 = 1; op0 = 0; a0 = 8'h11; b0 = 8'h22;
        cyc();
        a0 = 8'h55; b0 = 8'h66; op0 = 1;
        cyc();
        check("latch_s", s, 8'h33);
        req0 = 0;
        cyc();
        // Continuous contention from reset release.
        rst = 1;
        cyc();
        req0 = 1; op0 = 0; a0 = 8'h10; b0 = 8'h20;
        req1 = 1; op1 = 1; a1 = 8'h10; b1 = 8'h20;
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ack0) begin order.push_back(0); check("cont_s0", s, 8'h30); end
            if (ack1) begin
                order.push_back(1);
                check("cont_s1", s, 8'hF0);
                check("cont_co1", co, 0);
                check("cont_ovf1", ovf, 0);
            end
        end
        check("cont_count", order.size(), 4);
        foreach (order[i]) check("cont_order", order[i], i % 2);
        req0 = 0; req1 = 0;
        cyc();
        cyc();
        // Asynchronous reset while requester 1 is in EXEC.
        req1 = 1; op1 = 0; a1 = 8'h44; b1 = 8'h01;
        cyc();
        check("pre_rst_owner", owner, 1);
        #2 rst = 1;
        #1;
        check("arst_s", s, 0);
        check("arst_co", co, 0);
        check("arst_ovf", ovf, 0);
        check("arst_ack", {ack1, ack0}, 0);
        check("arst_owner", owner, 0);
        check("arst_busy", busy, 0);
        req0 = 1;
        cyc();
        rst = 0;
        cyc();
        check("post_rst_owner", owner, 0);
        cyc();
        check("post_rst_ack0", ack0, 1);
        req0 = 0; req1 = 0;
        cyc();
        // Random traffic: operands change every cycle, requests may drop early, rare resets.
        for (int i = 0; i < 800; i++) begin
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            op0 = 1'($urandom); op1 = 1'($urandom);
            req0 = $urandom_range(0, 3) != 0;
            req1 = $urandom_range(0, 2) != 0;
            rst  = $urandom_range(0, 99) == 0;
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin controller that shares one WIDTH-bit two's-complement add/subtract datapath between two requesters. It sits in front of the add/sub unit. Each request passes through a three-state sequence: grant and latch operands, compute and register the result, acknowledge. The owning requester gets the sum or difference, the raw carry-out and a signed-overflow flag. Carry and overflow are reported separately.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; asynchronous, active-high
- REQ0, REQ1  in  1  request from requester 0 / 1; held high until matching ACK
- OP0, OP1  in  1  operation for requester 0 / 1: 0 = A+B, 1 = A−B; stable while REQn high
- A0, B0, A1, B1  in  WIDTH  operands, two's complement; stable while REQn high
- ACK0, ACK1  out  1  one-cycle pulse: result for requester n valid on S/CO/OVF
- S  out  WIDTH  registered result
- CO  out  1  registered raw carry-out of the adder (for subtract: 1 = no borrow)
- OVF  out  1  registered signed overflow
- OWNER  out  1  index of requester granted most recently
- BUSY  out  1  high in EXEC and DONE

## Operation
- States: IDLE, EXEC, DONE. Reset state is IDLE.
- Internal registers:
  - LAST: last-served index, reset to 1, so requester 0 wins the first tie.
  - Latched operand registers: RA, RB, ROP.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQn high: grant n.
  - Both REQ high: grant ~LAST.
  - On grant: OWNER←n, RA←An, RB←Bn, ROP←OPn, go to EXEC.
- EXEC:
  - Compute {C, R} = RA + (RB XOR {WIDTH{ROP}}) + ROP, at WIDTH+1 bits.
  - S←R, CO←C.
  - OVF←(RA[W−1] == (RB[W−1] XOR ROP)) & (R[W−1] != RA[W−1]).
  - Go to DONE. Inputs are not sampled in EXEC.
- DONE:
  - ACK[OWNER]=1, the other ACK=0.
  - LAST←OWNER.
  - Go to IDLE unconditionally.
- ACK0/ACK1 are Moore outputs decoded from DONE and OWNER. They are never high together.
- S/CO/OVF/OWNER hold their values until overwritten by the next EXEC or grant.
- A REQn still high in the IDLE cycle after its ACK is a new request. It competes normally, and round-robin gives the other requester priority if both are pending.
- REQ dropped before ACK (protocol violation): the transaction still completes with the latched operands and ACK still pulses.
- RST asserted in any state:
  - State goes to IDLE immediately.
  - All outputs go to 0: S=0, CO=0, OVF=0, ACK0=ACK1=0, OWNER=0, BUSY=0.
  - LAST goes to 1.
  - Any in-flight transaction is discarded with no ACK.

## Timing
- Edge k samples REQ in IDLE: grant. BUSY and OWNER are valid after edge k.
- Edge k+1: result registered. State is DONE, ACKn high, and S/CO/OVF valid after edge k+1.
- Edge k+2: state is IDLE, ACKn low. The earliest next grant is edge k+3.
- Latency: 2 cycles from grant to ACK. Maximum throughput: one operation per 3 cycles.
- Continuous contention alternates grants: 0, 1, 0, 1, …
- A single continuous requester is served every 3 cycles.
- Operands need only be stable at the grant edge; they are latched there.

## Test plan
- WIDTH=8, REQ0 with OP0=0, A0=0x7F, B0=0x01 → ACK0 two edges after grant; S=0x80, CO=0, OVF=1, ACK1 stays 0.
- REQ1 with OP1=1, A1=0x80, B1=0x01 → S=0x7F, CO=1, OVF=1, OWNER=1. Then OP1=1, 0x05−0x05 → S=0x00, CO=1, OVF=0.
- REQ0 with OP0=0, A0=0xFF, B0=0x01 → S=0x00, CO=1, OVF=0 (unsigned carry without signed overflow).
- REQ0 and REQ1 both high from reset release and held:
  - Order of ACKs is ACK0, ACK1, ACK0, ACK1 at 3-cycle spacing.
  - Results match each requester's operands (A0=0x10,B0=0x20,OP0=0 → 0x30; A1=0x10,B1=0x20,OP1=1 → 0xF0, CO=0, OVF=0).
- Assert RST during EXEC after granting REQ1:
  - All outputs read 0 and no ACK occurs.
  - After release with both REQ high, requester 0 is granted first.
- Change A0/B0 on the cycle after the grant edge → result still reflects the values latched at grant.
